// File: rtl/eth_crc32_byte_if.sv
// Byte-serial CRC-32 bus: octet stream in, FCS-ordered CRC view out.
interface eth_crc32_byte_if;
    logic        updatecrc;
    logic [7:0]  data;
    logic [31:0] result;

    modport master (
        output updatecrc,
        output data,
        input  result
    );

    modport slave (
        input  updatecrc,
        input  data,
        output result
    );
endinterface

// File: rtl/eth_crc32_byte.sv
// Byte-serial Ethernet CRC-32 generator: folds one octet per clock into a
// reflected CRC state and exposes the complemented, FCS-ordered value.
module eth_crc32_byte #(
    parameter logic [31:0] INIT      = 32'hFFFF_FFFF,
    parameter logic [31:0] POLY_REFL = 32'hEDB8_8320,
    parameter logic [31:0] XOROUT    = 32'hFFFF_FFFF,
    parameter bit          SWAP_OUT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    eth_crc32_byte_if.slave   bus_io
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_x;

    function automatic logic [31:0] step8(input logic [31:0] x);
        logic [31:0] c;
        c = x;
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Data only reaches the state through the updatecrc mux, so X on an idle
    // data bus never propagates into crc_q.
    always_comb begin
        crc_d = crc_q;
        if (bus_io.updatecrc) begin
            crc_d = step8(crc_q ^ {24'h0, bus_io.data});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    always_comb begin
        crc_x = crc_q ^ XOROUT;
        if (SWAP_OUT) begin
            bus_io.result = {crc_x[7:0], crc_x[15:8], crc_x[23:16], crc_x[31:24]};
        end else begin
            bus_io.result = crc_x;
        end
    end

endmodule

// File: tb/tb_eth_crc32_byte.sv
// Directed bench for eth_crc32_byte: check string, gaps, residue, reset, full frame.
module tb_eth_crc32_byte;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    eth_crc32_byte_if bus ();

    eth_crc32_byte dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] CHECK_SWAP = 32'h2639_F4CB;

    // Bit-serial software model, default parameters, byte-swapped output.
    function automatic logic [31:0] model_crc(input logic [7:0] bytes[$]);
        logic [31:0] c;
        logic [31:0] v;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (bytes[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ bytes[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        v = ~c;
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic cycle(input logic upd, input logic [7:0] d);
        @(negedge clk);
        bus.updatecrc = upd;
        bus.data      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        bus.updatecrc = 1'b0;
        bus.data      = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic feed_digits(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cycle(1'b1, 8'h30 + 8'(i));
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        do_reset();
        total++;
        if (bus.result !== 32'h0000_0000) begin
            bad++;
            $display("FAIL reset_value: got %h want %h", bus.result, 32'h0);
        end
        for (int i = 0; i < 10; i++) begin
            rd = 8'($urandom);
            if (i % 3 == 2) rd = 8'bx;
            cycle(1'b0, rd);
            total++;
            if (bus.result !== 32'h0000_0000) begin
                bad++;
                $display("FAIL idle_hold[%0d]: got %h want %h", i, bus.result, 32'h0);
            end
        end
    endtask

    task automatic test_check_string();
        do_reset();
        cycle(1'b1, 8'h31);
        total++;
        if (bus.result !== 32'hB7EF_DC83) begin
            bad++;
            $display("FAIL one_octet_latency: got %h want %h", bus.result, 32'hB7EFDC83);
        end
        feed_digits(2, 9);
        total++;
        if (bus.result !== CHECK_SWAP) begin
            bad++;
            $display("FAIL check_string: got %h want %h", bus.result, CHECK_SWAP);
        end
    endtask

    task automatic test_single_zero();
        do_reset();
        cycle(1'b1, 8'h00);
        total++;
        if (bus.result !== 32'h8DEF_02D2) begin
            bad++;
            $display("FAIL single_zero: got %h want %h", bus.result, 32'h8DEF02D2);
        end
    endtask

    task automatic test_gap();
        do_reset();
        feed_digits(1, 4);
        cycle(1'b0, 8'hA5);
        cycle(1'b0, 8'bx);
        cycle(1'b0, 8'h5A);
        feed_digits(5, 9);
        total++;
        if (bus.result !== CHECK_SWAP) begin
            bad++;
            $display("FAIL gap_string: got %h want %h", bus.result, CHECK_SWAP);
        end
    endtask

    task automatic test_no_comb_path();
        // State from the previous test; changing inputs between edges must not move result.
        @(negedge clk);
        bus.updatecrc = 1'b1;
        bus.data      = 8'hFF;
        #1;
        total++;
        if (bus.result !== CHECK_SWAP) begin
            bad++;
            $display("FAIL no_comb_path: got %h want %h", bus.result, CHECK_SWAP);
        end
        bus.updatecrc = 1'b0;
    endtask

    task automatic test_residue();
        logic [31:0] crc_back;
        do_reset();
        feed_digits(1, 9);
        cycle(1'b1, CHECK_SWAP[31:24]);
        cycle(1'b1, CHECK_SWAP[23:16]);
        cycle(1'b1, CHECK_SWAP[15:8]);
        cycle(1'b1, CHECK_SWAP[7:0]);
        total++;
        if (bus.result !== 32'h1CDF_4421) begin
            bad++;
            $display("FAIL residue_result: got %h want %h", bus.result, 32'h1CDF4421);
        end
        crc_back = {bus.result[7:0], bus.result[15:8], bus.result[23:16], bus.result[31:24]}
                   ^ 32'hFFFF_FFFF;
        total++;
        if (crc_back !== 32'hDEBB_20E3) begin
            bad++;
            $display("FAIL residue_state: got %h want %h", crc_back, 32'hDEBB20E3);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        feed_digits(1, 4);
        @(negedge clk);
        rst           = 1'b0;
        bus.updatecrc = 1'b1;
        bus.data      = 8'h77;
        @(posedge clk);
        #1;
        total++;
        if (bus.result !== 32'h0000_0000) begin
            bad++;
            $display("FAIL reset_overrides_update: got %h want %h", bus.result, 32'h0);
        end
        @(negedge clk);
        rst           = 1'b1;
        bus.updatecrc = 1'b0;
        feed_digits(1, 9);
        total++;
        if (bus.result !== CHECK_SWAP) begin
            bad++;
            $display("FAIL mid_reset_restart: got %h want %h", bus.result, CHECK_SWAP);
        end
    endtask

    task automatic test_frame();
        logic [7:0]  frame[$];
        logic [31:0] exp_val;
        frame = '{8'h02, 8'h35, 8'h28, 8'hFB, 8'hDD, 8'h66,
                  8'h07, 8'h22, 8'h27, 8'hAC, 8'hDB, 8'h65,
                  8'h00, 8'h2E};
        for (int i = 0; i < 46; i++) frame.push_back(8'h00);
        exp_val = model_crc(frame);
        do_reset();
        foreach (frame[k]) cycle(1'b1, frame[k]);
        total++;
        if (bus.result !== exp_val) begin
            bad++;
            $display("FAIL frame60: got %h want %h", bus.result, exp_val);
        end
        cycle(1'b0, 8'h00);
        total++;
        if (bus.result !== exp_val) begin
            bad++;
            $display("FAIL frame60_hold: got %h want %h", bus.result, exp_val);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        bus.updatecrc = 1'b0;
        bus.data      = 8'h00;
        test_reset();
        test_check_string();
        test_single_zero();
        test_gap();
        test_no_comb_path();
        test_residue();
        test_mid_reset();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
